seq_multdiv: RTL

SEQ_MULTDIV -- requirements
Module: seq_multdiv

---
 rtl/seq_multdiv.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/seq_multdiv.sv
// seq_multdiv: sequential signed multiplier (radix-2 Booth) and divider (restoring, on magnitudes).
// Latency: WIDTH+1 cycles from a sampled start to the one-cycle data_resultRDY pulse.
// Divide-by-zero finishes after 1 cycle. A request made with both controls high finishes after 0 cycles.
// Backpressure: none. A new start is accepted in any state and aborts the operation in progress.
//
// Ports:
//   clock, reset         - single clock; synchronous active-high reset
//   data_operandA/B      - multiplicand/dividend and multiplier/divisor, two's complement
//   ctrl_MULT/ctrl_DIV   - start requests; both high together is an illegal request
//   data_result          - low product word / quotient
//   data_result_hi       - high product word / remainder; tied to 0 unless MULTDIV_HI_RESULT_EN is defined
//   data_exception       - overflow, divide-by-zero or illegal request; qualified by data_resultRDY
//   data_resultRDY       - one-cycle completion pulse
//   busy                 - high while iterating
//
// Optional feature macro: MULTDIV_HI_RESULT_EN builds the high-word/remainder output register.

module seq_multdiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_result_hi,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state;
    state_t state_nxt;

    // Shared iteration registers.
    //   MUL: acc = Booth accumulator (one guard bit), qreg = multiplier / low product,
    //        qm1 = Booth q(-1) bit, mreg = sign-extended multiplicand.
    //   DIV: acc = partial remainder, qreg = dividend magnitude shifting into quotient,
    //        mreg = {0, divisor magnitude}.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qreg;
    logic             qm1;
    logic [WIDTH:0]   mreg;
    logic [CNT_W-1:0] cnt;
    logic             sign_a;
    logic             sign_b;

    logic [WIDTH-1:0] res_reg;
    logic             exc_reg;

    logic             illegal;
    logic             start_mul;
    logic             start_div;
    logic             dvs_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    logic [WIDTH-1:0] res_nxt;
    logic             exc_nxt;
`ifdef MULTDIV_HI_RESULT_EN
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] hi_nxt;
`endif

    assign illegal   = ctrl_MULT & ctrl_DIV;
    assign start_mul = ctrl_MULT & ~ctrl_DIV;
    assign start_div = ctrl_DIV & ~ctrl_MULT;
    assign dvs_zero  = (mreg[WIDTH-1:0] == '0);

    // The most negative value negates to itself, which is the correct unsigned magnitude.
    assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (illegal) begin
            state_nxt = DONE;
        end else if (start_mul) begin
            state_nxt = MUL;
        end else if (start_div) begin
            state_nxt = DIV;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                MUL:  state_nxt = (cnt == CNT_LAST) ? DONE : MUL;
                DIV:  state_nxt = (dvs_zero || cnt == CNT_LAST) ? DONE : DIV;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign data_resultRDY = (state == DONE);
    assign busy           = (state == MUL) || (state == DIV);

    // ---------------- Iteration step logic ----------------
    always_comb begin
        case ({qreg[0], qm1})
            2'b01:   booth_sum = acc + mreg;
            2'b10:   booth_sum = acc - mreg;
            default: booth_sum = acc;
        endcase
    end

    // The partial remainder is always below the divisor, so after the shift it fits in WIDTH+1 bits.
    assign div_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    assign div_ge    = (div_shift >= mreg);
    assign div_diff  = div_shift - mreg;

    // ---------------- Final result selection (loaded on entry to DONE) ----------------
    always_comb begin
        res_nxt = '0;
        exc_nxt = 1'b1;
`ifdef MULTDIV_HI_RESULT_EN
        hi_nxt  = '0;
`endif
        if (illegal) begin
            res_nxt = '0;
            exc_nxt = 1'b1;
        end else if (state == MUL) begin
            res_nxt = qreg;
            // The product fits iff the high word is pure sign extension of the low word.
            exc_nxt = (acc[WIDTH-1:0] != {WIDTH{qreg[WIDTH-1]}});
`ifdef MULTDIV_HI_RESULT_EN
            hi_nxt  = acc[WIDTH-1:0];
`endif
        end else if (state == DIV && !dvs_zero) begin
            res_nxt = (sign_a ^ sign_b) ? (~qreg + 1'b1) : qreg;
            // A positive quotient with its top bit set arises only from MIN / -1.
            exc_nxt = ~(sign_a ^ sign_b) & qreg[WIDTH-1];
`ifdef MULTDIV_HI_RESULT_EN
            hi_nxt  = sign_a ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
`endif
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            acc     <= '0;
            qreg    <= '0;
            qm1     <= 1'b0;
            mreg    <= '0;
            cnt     <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            res_reg <= '0;
            exc_reg <= 1'b0;
        end else begin
            if (start_mul) begin
                acc  <= '0;
                qreg <= data_operandB;
                qm1  <= 1'b0;
                mreg <= {data_operandA[WIDTH-1], data_operandA};
                cnt  <= '0;
            end else if (start_div) begin
                acc    <= '0;
                qreg   <= abs_a;
                qm1    <= 1'b0;
                mreg   <= {1'b0, abs_b};
                sign_a <= data_operandA[WIDTH-1];
                sign_b <= data_operandB[WIDTH-1];
                cnt    <= '0;
            end else if (!illegal && state == MUL && cnt != CNT_LAST) begin
                // Arithmetic right shift of {acc, qreg, qm1} after the Booth add/subtract.
                acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                qreg <= {booth_sum[0], qreg[WIDTH-1:1]};
                qm1  <= qreg[0];
                cnt  <= cnt + CNT_ONE;
            end else if (!illegal && state == DIV && !dvs_zero && cnt != CNT_LAST) begin
                acc  <= div_ge ? div_diff : div_shift;
                qreg <= {qreg[WIDTH-2:0], div_ge};
                cnt  <= cnt + CNT_ONE;
            end

            if (state_nxt == DONE) begin
                res_reg <= res_nxt;
                exc_reg <= exc_nxt;
            end
        end
    end

`ifdef MULTDIV_HI_RESULT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_reg <= '0;
        end else if (state_nxt == DONE) begin
            hi_reg <= hi_nxt;
        end
    end

    assign data_result_hi = hi_reg;
`else
    assign data_result_hi = '0;
`endif

    assign data_result    = res_reg;
    assign data_exception = exc_reg;

endmodule
